id_ex_pipe: RTL

ID_EX_PIPE -- requirements
Module: id_ex_pipe

---
 rtl/id_ex_pipe.sv | 127 ++++++++++++
 1 files changed

// File: rtl/id_ex_pipe.sv
// rtl/id_ex_pipe.sv - ID/EX pipeline stage with valid/ready handshake and flush; ID_EX_SKID_EN adds a skid register
module id_ex_pipe #(
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_i,
    input  logic [31:0] inst_addr_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        rd_wen_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic        flush_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic [31:0] op1_o,
    output logic [31:0] op2_o,
    output logic [4:0]  rd_addr_o,
    output logic        rd_wen_o,
    output logic        valid_o,
    input  logic        ready_i
);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd_addr;
        logic        rd_wen;
    } beat_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    beat_t  main_q;
    beat_t  in_beat;
    logic   accept;
    logic   deliver;

    assign in_beat = {inst_i, inst_addr_i, op1_i, op2_i, rd_addr_i, rd_wen_i};
    assign valid_o = (state != EMPTY);
    assign deliver = valid_o && ready_i;
    assign accept  = valid_i && ready_o;

`ifdef ID_EX_SKID_EN
    beat_t skid_q;
    logic  ready_q;

    // ready_q mirrors state != FULL so upstream sees a flop, not a path from ready_i
    assign ready_o = ready_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= EMPTY;
            ready_q <= 1'b1;
            main_q  <= '0;
            skid_q  <= '0;
        end else if (flush_i) begin
            state   <= EMPTY;
            ready_q <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_q <= in_beat;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (accept && deliver) begin
                        main_q <= in_beat;
                    end else if (accept) begin
                        skid_q  <= in_beat;
                        state   <= FULL;
                        ready_q <= 1'b0;
                    end else if (deliver) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (deliver) begin
                        main_q  <= skid_q;
                        state   <= ONE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end
`else
    assign ready_o = !valid_o || ready_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= EMPTY;
            main_q <= '0;
        end else if (flush_i) begin
            state <= EMPTY;
        end else if (accept) begin
            main_q <= in_beat;
            state  <= ONE;
        end else if (deliver) begin
            state <= EMPTY;
        end
    end
`endif

    // Empty stage presents a bubble so EX never acts on stale payload
    assign inst_o      = valid_o ? main_q.inst    : NOP_INST;
    assign inst_addr_o = valid_o ? main_q.addr    : 32'd0;
    assign op1_o       = valid_o ? main_q.op1     : 32'd0;
    assign op2_o       = valid_o ? main_q.op2     : 32'd0;
    assign rd_addr_o   = valid_o ? main_q.rd_addr : 5'd0;
    assign rd_wen_o    = valid_o ? main_q.rd_wen  : 1'b0;

endmodule
